// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from the timing generator to its consumers
// hsync/vsync active-low syncs; col/row pixel coordinates; valid active-video flag;
// frame_tick one-clk pulse at start of vertical blanking; frame_count frames since reset.
interface vga_timing_if;
  logic       hsync;
  logic       vsync;
  logic [9:0] col;
  logic [9:0] row;
  logic       valid;
  logic       frame_tick;
  logic [7:0] frame_count;
  modport master (output hsync, vsync, col, row, valid, frame_tick, frame_count);
  modport slave  (input  hsync, vsync, col, row, valid, frame_tick, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing with pixel coordinates, frame tick and frame counter
// clk: system clock; reset: synchronous active-high; vga: master side of vga_timing_if.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1
) (
  input logic         clk,
  input logic         reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_size_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
  end
  if (CLK_DIV != 1 && CLK_DIV != 2) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be 1 or 2");
  end
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       DIV1   = (CLK_DIV == 1);
  // run_q is low during reset and for the reset-release edge, so (0,0) is shown for a full pixel after release
  logic       run_q;
  logic       div_q;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic [7:0] fc_q;
  logic       pix_en, h_last, v_last, tick;
  always_comb begin
    pix_en = run_q && (DIV1 || div_q);
    h_last = col_q == H_LAST;
    v_last = row_q == V_LAST;
    col_d  = !pix_en ? col_q : h_last ? 10'd0 : col_q + 10'd1;
    row_d  = !(pix_en && h_last) ? row_q : v_last ? 10'd0 : row_q + 10'd1;
    // div_q is 0 on the first clk of every pixel, so the tick fires once even when CLK_DIV=2
    tick   = run_q && !div_q && col_q == 10'd0 && row_q == V_ACT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      fc_q  <= '0;
    end else begin
      run_q <= 1'b1;
      div_q <= run_q && !pix_en;
      col_q <= col_d;
      row_q <= row_d;
      fc_q  <= fc_q + 8'(tick);
    end
  end
  assign vga.col         = col_q;
  assign vga.row         = row_q;
  assign vga.hsync       = !(col_q >= HS_BEG && col_q < HS_END);
  assign vga.vsync       = !(row_q >= VS_BEG && row_q < VS_END);
  assign vga.valid       = run_q && col_q < H_ACT && row_q < V_ACT;
  assign vga.frame_tick  = tick;
  assign vga.frame_count = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen using a small raster at CLK_DIV 1 and 2
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  typedef struct {
    int   n;
    int   col;
    int   row;
    logic valid;
    logic hs;
    logic vs;
    logic tick;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vga_timing_if v1 ();
  vga_timing_if v2 ();
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(1))
    dut1 (.clk(clk), .reset(reset), .vga(v1));
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2))
    dut2 (.clk(clk), .reset(reset), .vga(v2));
  int checks = 0;
  int failures = 0;
  int mt[2];
  int mticks[2];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_out(input int d, output int c, output int r, output int va,
                           output int hs, output int vs, output int tk);
    int dv, p;
    dv = d + 1;
    if (mt[d] < 0) begin
      c = 0; r = 0; va = 0; hs = 1; vs = 1; tk = 0;
    end else begin
      p  = mt[d] / dv;
      c  = p % HT;
      r  = (p / HT) % VT;
      va = (c < HA && r < VA) ? 1 : 0;
      hs = (c >= HA + HF && c < HA + HF + HS) ? 0 : 1;
      vs = (r >= VA + VF && r < VA + VF + VS) ? 0 : 1;
      tk = (mt[d] % dv == 0 && c == 0 && r == VA) ? 1 : 0;
    end
  endtask
  task automatic check_all();
    int c, r, va, hs, vs, tk;
    for (int d = 0; d < 2; d++) begin
      model_out(d, c, r, va, hs, vs, tk);
      if (d == 0) begin
        chk("d1.col", v1.col, c);     chk("d1.row", v1.row, r);
        chk("d1.valid", v1.valid, va); chk("d1.hsync", v1.hsync, hs);
        chk("d1.vsync", v1.vsync, vs); chk("d1.tick", v1.frame_tick, tk);
        chk("d1.fcount", v1.frame_count, mticks[0] % 256);
      end else begin
        chk("d2.col", v2.col, c);     chk("d2.row", v2.row, r);
        chk("d2.valid", v2.valid, va); chk("d2.hsync", v2.hsync, hs);
        chk("d2.vsync", v2.vsync, vs); chk("d2.tick", v2.frame_tick, tk);
        chk("d2.fcount", v2.frame_count, mticks[1] % 256);
      end
    end
  endtask
  task automatic run(input logic r);
    int c, rw, va, hs, vs;
    int tk[2];
    reset = r;
    for (int d = 0; d < 2; d++) model_out(d, c, rw, va, hs, vs, tk[d]);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        mt[d] = -1;
        mticks[d] = 0;
      end else begin
        mticks[d] += tk[d];
        mt[d]++;
      end
    end
    check_all();
  endtask
  task automatic restart();
    run(1'b1);
    run(1'b1);
    run(1'b0);
  endtask
  vec_t vecs[15];
  initial begin
    int lows1, lows2, tk1, found;
    bit prev;
    mt[0] = -1; mt[1] = -1; mticks[0] = 0; mticks[1] = 0;
    vecs[0]  = '{0,   0,  0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{7,   7,  0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{8,   8,  0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{10, 10,  0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{12, 12,  0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{13, 13,  0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{14, 14,  0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{15,  0,  1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{90,  0,  6, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{91,  1,  6, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{105, 0,  7, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{134, 14, 8, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{135, 0,  9, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{149, 14, 9, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{150, 0,  0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 15; i++) begin
      restart();
      repeat (vecs[i].n) run(1'b0);
      chk("tbl.col", v1.col, vecs[i].col);
      chk("tbl.row", v1.row, vecs[i].row);
      chk("tbl.valid", v1.valid, vecs[i].valid);
      chk("tbl.hsync", v1.hsync, vecs[i].hs);
      chk("tbl.vsync", v1.vsync, vecs[i].vs);
      chk("tbl.tick", v1.frame_tick, vecs[i].tick);
    end
    restart();
    repeat (65) run(1'b0);
    chk("mid.col", v1.col, 5);
    chk("mid.row", v1.row, 4);
    repeat (5) begin
      run(1'b1);
      chk("rst.col", v1.col, 0);     chk("rst.row", v1.row, 0);
      chk("rst.valid", v1.valid, 0); chk("rst.hsync", v1.hsync, 1);
      chk("rst.vsync", v1.vsync, 1); chk("rst.fcount", v1.frame_count, 0);
      chk("rst.tick", v1.frame_tick, 0);
    end
    run(1'b0);
    chk("rel.col", v1.col, 0);
    chk("rel.row", v1.row, 0);
    chk("rel.valid", v1.valid, 1);
    restart();
    lows1 = 0;
    lows2 = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      if (i < HT && !v1.hsync) lows1++;
      if (!v2.hsync) lows2++;
      run(1'b0);
    end
    chk("div1.hs_width", lows1, HS);
    chk("div2.hs_width", lows2, 2 * HS);
    chk("div2.line_col", v2.col, 0);
    chk("div2.line_row", v2.row, 1);
    restart();
    found = 0;
    for (int i = 0; i < 500 && found == 0; i++) begin
      run(1'b0);
      if (v1.frame_tick) found = 1;
    end
    chk("tickrst.first_tick", found, 1);
    run(1'b1);
    chk("tickrst.fcount", v1.frame_count, 0);
    run(1'b1);
    run(1'b0);
    found = 0;
    for (int i = 1; i <= 500 && found == 0; i++) begin
      run(1'b0);
      if (v1.frame_tick) found = i;
    end
    chk("tickrst.next_tick_delay", found, HT * VA);
    chk("tickrst.fcount_after", v1.frame_count, 0);
    restart();
    tk1 = 0;
    prev = 0;
    for (int i = 0; i < 150 * 256 + 110; i++) begin
      if (prev && tk1 == 255) chk("frames.fc255", v1.frame_count, 255);
      if (prev && tk1 == 256) chk("frames.fc0", v1.frame_count, 0);
      if (prev && tk1 == 257) chk("frames.fc1", v1.frame_count, 1);
      prev = v1.frame_tick;
      tk1 += int'(v1.frame_tick);
      run(1'b0);
    end
    chk("frames.tick_count", tk1, 257);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 400)) run(1'b0);
      repeat ($urandom_range(1, 4)) run(1'b1);
    end
    repeat (200) run(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
